// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the execute stage.
//   - control word layout (ctrl_t, 17 bits, bits [16:14] reserved and must be 0)
//   - ALU op encodings, branch condition codes, execute FSM state enum
package exe_pkg;

  localparam int CTRL_W = 17;

  typedef struct packed {
    logic [2:0] rsvd;     // [16:14]
    logic       mac_clr;  // [13]
    logic       mac;      // [12]
    logic       mul;      // [11]
    logic [1:0] br_cond;  // [10:9]
    logic       br;       // [8]
    logic       reg_wr;   // [7]
    logic       mem_wr;   // [6]
    logic       mem_rd;   // [5]
    logic       use_imm;  // [4]
    logic [3:0] alu_op;   // [3:0]
  } ctrl_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_PASSB = 4'd9
  } alu_op_e;

  localparam logic [1:0] BR_ALWAYS = 2'b00;
  localparam logic [1:0] BR_EQ     = 2'b01;
  localparam logic [1:0] BR_NE     = 2'b10;
  localparam logic [1:0] BR_LT     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// exe_mul_iter: iterative shift-add multiplier, MUL_STEP multiplier bits per cycle.
//   The first step is taken in the start cycle straight from i_a/i_b, the remaining
//   DATA_W/MUL_STEP-1 steps run while busy. o_done pulses in the final step cycle with
//   o_product holding the finished low DATA_W bits (identical for signed/unsigned).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   i_start         load operands and take step 0 (ignored while busy)
//   i_abort         drop the in-flight product
//   i_a, i_b        multiplicand, multiplier
//   o_busy          steps remaining
//   o_done          final step this cycle; o_product is valid
//   o_product       running/final product
module exe_mul_iter #(
  parameter int DATA_W   = 32,
  parameter int MUL_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_product
);

  localparam int STEPS = DATA_W / MUL_STEP;
  localparam int CW    = $clog2(STEPS) + 1;

  logic              r_busy;
  logic [CW-1:0]     r_cnt;   // steps left, including the one in this cycle
  logic [DATA_W-1:0] r_a, r_b, r_p;
  logic [DATA_W-1:0] w_a, w_b, w_p, w_p_nxt;

  // One radix-2^MUL_STEP step: add the multiplicand shifted by each set multiplier bit.
  always_comb begin
    w_a     = r_busy ? r_a : i_a;
    w_b     = r_busy ? r_b : i_b;
    w_p     = r_busy ? r_p : '0;
    w_p_nxt = w_p;
    for (int j = 0; j < MUL_STEP; j++)
      if (w_b[j]) w_p_nxt = w_p_nxt + (w_a << j);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_p   <= w_p_nxt;
      r_a   <= w_a << MUL_STEP;
      r_b   <= w_b >> MUL_STEP;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end else if (i_start) begin
      r_p    <= w_p_nxt;
      r_a    <= w_a << MUL_STEP;
      r_b    <= w_b >> MUL_STEP;
      r_cnt  <= CW'(STEPS - 1);
      r_busy <= 1'b1;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy & (r_cnt == CW'(1)) & ~i_abort;
  assign o_product = w_p_nxt;

endmodule

// File: rtl/exe_stage.sv
// exe_stage: execute stage between the REG/EXE and EXE/MEM pipeline registers.
//   Single-cycle ALU, branch resolution, load/store address generation, and an
//   iterative MUL/MAC (stalls upstream) with one architectural accumulator.
//   Optional build macro EXE_MAC_SAT_EN: MAC add saturates and a sticky sat_seen
//   flag is kept; otherwise MAC wraps.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_valid/i_flush   instruction present / kill current or in-flight instruction
//   i_ctrl            control word (exe_pkg::ctrl_t)
//   i_pc, i_DatA, i_DatB, i_imm, i_Off21, i_OffStore, i_Robj   instruction operands
//   o_stall           upstream must hold
//   o_valid, o_result, o_addr, o_store_data, o_Robj, o_mem_ctrl  EXE/MEM outputs
//   o_br_taken, o_br_target   branch resolution, qualified by o_valid
module exe_stage
  import exe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 4,
  parameter int CTRL_W   = 17,
  parameter int MUL_STEP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_flush,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_DatA,
  input  logic [DATA_W-1:0] i_DatB,
  input  logic [DATA_W-1:0] i_imm,
  input  logic [DATA_W-1:0] i_Off21,
  input  logic [DATA_W-1:0] i_OffStore,
  input  logic [REG_W-1:0]  i_Robj,
  output logic              o_stall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic [DATA_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_store_data,
  output logic [REG_W-1:0]  o_Robj,
  output logic [2:0]        o_mem_ctrl,
  output logic              o_br_taken,
  output logic [DATA_W-1:0] o_br_target
);

  localparam int MSB = DATA_W - 1;

  ctrl_t             w_c;
  logic [DATA_W-1:0] w_opb, w_alu;
  logic              w_cond, w_take, w_take_m, w_abort, w_ovalid;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_prod, w_base, w_mac;
  state_e            r_state, w_state_n;

  logic              r_valid, r_br_taken, r_is_mac, r_clr;
  logic [DATA_W-1:0] r_result, r_addr, r_store, r_br_target;
  logic [DATA_W-1:0] r_acc, r_acc_pend;
  logic [REG_W-1:0]  r_robj;
  logic [2:0]        r_mem_ctrl;

  assign w_c   = ctrl_t'(i_ctrl);
  assign w_opb = w_c.use_imm ? i_imm : i_DatB;

  // ALU; a non-zero reserved field is treated like an undefined op.
  always_comb begin
    w_alu = '0;
    if (w_c.rsvd == 3'b000) begin
      case (w_c.alu_op)
        ALU_ADD:   w_alu = i_DatA + w_opb;
        ALU_SUB:   w_alu = i_DatA - w_opb;
        ALU_AND:   w_alu = i_DatA & w_opb;
        ALU_OR:    w_alu = i_DatA | w_opb;
        ALU_XOR:   w_alu = i_DatA ^ w_opb;
        ALU_SLL:   w_alu = i_DatA << w_opb[4:0];
        ALU_SRL:   w_alu = i_DatA >> w_opb[4:0];
        ALU_SRA:   w_alu = DATA_W'($signed(i_DatA) >>> w_opb[4:0]);
        ALU_SLT:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(i_DatA) < $signed(w_opb))};
        ALU_PASSB: w_alu = w_opb;
        default:   w_alu = '0;
      endcase
    end
  end

  always_comb begin
    w_cond = 1'b0;
    case (w_c.br_cond)
      BR_ALWAYS: w_cond = 1'b1;
      BR_EQ:     w_cond = (i_DatA == i_DatB);
      BR_NE:     w_cond = (i_DatA != i_DatB);
      BR_LT:     w_cond = ($signed(i_DatA) < $signed(i_DatB));
      default:   w_cond = 1'b0;
    endcase
  end

  // New instructions are taken in IDLE and also in DONE (back-to-back issue).
  assign w_take   = rst_n & i_valid & ~i_flush & (r_state != ST_MUL);
  assign w_take_m = w_take & (w_c.mul | w_c.mac);
  assign w_abort  = (r_state == ST_MUL) & i_flush;
  assign o_stall  = rst_n & ((r_state == ST_MUL) | w_take_m);

  exe_mul_iter #(.DATA_W(DATA_W), .MUL_STEP(MUL_STEP)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_take_m),
    .i_abort   (w_abort),
    .i_a       (i_DatA),
    .i_b       (w_opb),
    .o_busy    (),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  assign w_base = r_clr ? '0 : r_acc;

`ifdef EXE_MAC_SAT_EN
  logic              w_ovf;
  logic [DATA_W-1:0] w_sum;
  logic              r_sat_pend, r_sat_seen;

  // Signed overflow: addends share a sign that the sum does not.
  always_comb begin
    w_sum = w_base + w_prod;
    w_ovf = ~r_clr & (r_acc[MSB] == w_prod[MSB]) & (w_sum[MSB] != r_acc[MSB]);
    w_mac = w_sum;
    if (w_ovf) w_mac = r_acc[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_pend <= 1'b0;
      r_sat_seen <= 1'b0;
    end else begin
      if ((r_state == ST_MUL) && w_mul_done) r_sat_pend <= w_ovf;
      if ((r_state == ST_DONE) && !i_flush && r_is_mac)
        r_sat_seen <= (r_sat_seen & ~r_clr) | r_sat_pend;
    end
  end
`else
  assign w_mac = w_base + w_prod;
`endif

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE: if (w_take_m) w_state_n = ST_MUL;
      ST_MUL: begin
        if (i_flush)         w_state_n = ST_IDLE;
        else if (w_mul_done) w_state_n = ST_DONE;
      end
      ST_DONE: w_state_n = w_take_m ? ST_MUL : ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  // The MAC result is held pending through DONE and only committed to the
  // accumulator if DONE is not flushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_br_taken  <= 1'b0;
      r_result    <= '0;
      r_addr      <= '0;
      r_store     <= '0;
      r_br_target <= '0;
      r_robj      <= '0;
      r_mem_ctrl  <= '0;
      r_is_mac    <= 1'b0;
      r_clr       <= 1'b0;
      r_acc       <= '0;
      r_acc_pend  <= '0;
    end else begin
      r_valid    <= 1'b0;
      r_br_taken <= 1'b0;
      if (w_take) begin
        r_robj      <= i_Robj;
        r_mem_ctrl  <= {w_c.reg_wr, w_c.mem_wr, w_c.mem_rd};
        r_store     <= i_DatB;
        r_addr      <= i_DatA + i_OffStore;
        r_br_target <= i_pc + i_Off21;
        r_is_mac    <= w_c.mac;
        r_clr       <= w_c.mac_clr;
        if (!w_take_m) begin
          r_valid    <= 1'b1;
          r_result   <= w_alu;
          r_br_taken <= w_c.br & w_cond;
        end
      end else if ((r_state == ST_MUL) && w_mul_done) begin
        r_valid  <= 1'b1;
        r_result <= r_is_mac ? w_mac : w_prod;
        if (r_is_mac) r_acc_pend <= w_mac;
      end
      if ((r_state == ST_DONE) && !i_flush && r_is_mac) r_acc <= r_acc_pend;
    end
  end

  assign w_ovalid     = r_valid & ~((r_state == ST_DONE) & i_flush);
  assign o_valid      = w_ovalid;
  assign o_result     = r_result;
  assign o_addr       = r_addr;
  assign o_store_data = r_store;
  assign o_Robj       = r_robj;
  assign o_mem_ctrl   = w_ovalid ? r_mem_ctrl : 3'b000;
  assign o_br_taken   = w_ovalid & r_br_taken;
  assign o_br_target  = r_br_target;

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage: ALU, branches, MUL/MAC timing, flush, reset.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_flush;
  logic [16:0] i_ctrl;
  logic [31:0] i_pc, i_DatA, i_DatB, i_imm, i_Off21, i_OffStore;
  logic [3:0]  i_Robj;
  logic        o_stall, o_valid, o_br_taken;
  logic [31:0] o_result, o_addr, o_store_data, o_br_target;
  logic [3:0]  o_Robj;
  logic [2:0]  o_mem_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage #(.DATA_W(32), .REG_W(4), .CTRL_W(17), .MUL_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_flush(i_flush), .i_ctrl(i_ctrl),
    .i_pc(i_pc), .i_DatA(i_DatA), .i_DatB(i_DatB), .i_imm(i_imm), .i_Off21(i_Off21),
    .i_OffStore(i_OffStore), .i_Robj(i_Robj), .o_stall(o_stall), .o_valid(o_valid),
    .o_result(o_result), .o_addr(o_addr), .o_store_data(o_store_data), .o_Robj(o_Robj),
    .o_mem_ctrl(o_mem_ctrl), .o_br_taken(o_br_taken), .o_br_target(o_br_target)
  );

  // Control word: {rsvd, mac_clr, mac, mul, br_cond, br, reg_wr, mem_wr, mem_rd, use_imm, alu_op}
  function automatic logic [16:0] ctl(input logic [3:0] op, input logic imm, input logic rd,
                                      input logic wr, input logic rw, input logic br,
                                      input logic [1:0] cond, input logic mul,
                                      input logic mac, input logic clr);
    return {3'b000, clr, mac, mul, cond, br, rw, wr, rd, imm, op};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [16:0] c, input logic [31:0] a, input logic [31:0] b);
    i_valid = 1'b1; i_ctrl = c; i_DatA = a; i_DatB = b;
  endtask

  // Bounded wait for o_valid; n is the number of cycles waited.
  task automatic wait_valid(output int n);
    n = 0;
    while (o_valid !== 1'b1 && n < 40) begin tick(); n++; end
  endtask

  logic [3:0]  v_op  [13];
  logic [31:0] v_a   [13];
  logic [31:0] v_b   [13];
  logic [31:0] v_exp [13];
  int n, vcnt;

  initial begin
    v_op[0]  = 4'd0; v_a[0]  = 32'd7;         v_b[0]  = 32'd5;         v_exp[0]  = 32'd12;
    v_op[1]  = 4'd1; v_a[1]  = 32'd3;         v_b[1]  = 32'd5;         v_exp[1]  = 32'hFFFFFFFE;
    v_op[2]  = 4'd2; v_a[2]  = 32'hF0F0;      v_b[2]  = 32'hFF00;      v_exp[2]  = 32'hF000;
    v_op[3]  = 4'd3; v_a[3]  = 32'hF0F0;      v_b[3]  = 32'h0F0F;      v_exp[3]  = 32'hFFFF;
    v_op[4]  = 4'd4; v_a[4]  = 32'hFFFF;      v_b[4]  = 32'h00FF;      v_exp[4]  = 32'hFF00;
    v_op[5]  = 4'd5; v_a[5]  = 32'd1;         v_b[5]  = 32'd31;        v_exp[5]  = 32'h80000000;
    v_op[6]  = 4'd6; v_a[6]  = 32'h80000000;  v_b[6]  = 32'd4;         v_exp[6]  = 32'h08000000;
    v_op[7]  = 4'd7; v_a[7]  = 32'h80000000;  v_b[7]  = 32'd4;         v_exp[7]  = 32'hF8000000;
    v_op[8]  = 4'd8; v_a[8]  = 32'hFFFFFFFF;  v_b[8]  = 32'd1;         v_exp[8]  = 32'd1;
    v_op[9]  = 4'd8; v_a[9]  = 32'd1;         v_b[9]  = 32'hFFFFFFFF;  v_exp[9]  = 32'd0;
    v_op[10] = 4'd9; v_a[10] = 32'd0;         v_b[10] = 32'hDEADBEEF;  v_exp[10] = 32'hDEADBEEF;
    v_op[11] = 4'hF; v_a[11] = 32'd5;         v_b[11] = 32'd5;         v_exp[11] = 32'd0;
    v_op[12] = 4'd0; v_a[12] = 32'hFFFFFFFF;  v_b[12] = 32'd2;         v_exp[12] = 32'd1;

    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ctrl = '0; i_pc = '0; i_DatA = '0;
    i_DatB = '0; i_imm = '0; i_Off21 = '0; i_OffStore = '0; i_Robj = '0;
    tick(); tick();
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    chk("rst_stall", o_stall, 0);
    chk("rst_memctrl", o_mem_ctrl, 0);
    chk("rst_br", o_br_taken, 0);
    rst_n = 1'b1;

    // ADD 7+5
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0), 32'd7, 32'd5); i_Robj = 4'd3;
    #1 chk("add_stall", o_stall, 0);
    tick();
    chk("add_valid", o_valid, 1);
    chk("add_result", o_result, 12);
    chk("add_memctrl", o_mem_ctrl, 3'b100);
    chk("add_robj", o_Robj, 4'd3);

    // back-to-back ALU vectors
    for (int k = 0; k < 13; k++) begin
      drv(ctl(v_op[k], 0, 0, 0, 1, 0, 2'b00, 0, 0, 0), v_a[k], v_b[k]);
      tick();
      chk($sformatf("alu%0d_valid", k), o_valid, 1);
      chk($sformatf("alu%0d_result", k), o_result, v_exp[k]);
    end

    // immediate operand
    drv(ctl(4'd0, 1, 0, 0, 1, 0, 2'b00, 0, 0, 0), 32'd10, 32'd99); i_imm = 32'd5;
    tick();
    chk("imm_result", o_result, 15);

    // store: address generation and store data
    drv(ctl(4'd0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0), 32'h1000, 32'hCAFE); i_OffStore = 32'h10;
    tick();
    chk("st_addr", o_addr, 32'h1010);
    chk("st_data", o_store_data, 32'hCAFE);
    chk("st_memctrl", o_mem_ctrl, 3'b010);
    i_valid = 1'b0;
    tick();
    chk("idle_valid", o_valid, 0);
    chk("idle_memctrl", o_mem_ctrl, 0);

    // branches
    i_pc = 32'h100; i_Off21 = 32'hFFFFFFF8;
    drv(ctl(4'd0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0), 32'd9, 32'd9);
    tick();
    chk("beq_taken", o_br_taken, 1);
    chk("beq_target", o_br_target, 32'hF8);
    chk("beq_memctrl", o_mem_ctrl, 0);
    drv(ctl(4'd0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0), 32'd9, 32'd3);
    tick();
    chk("beq_ne", o_br_taken, 0);
    drv(ctl(4'd0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0), 32'd9, 32'd3);
    tick();
    chk("bne_taken", o_br_taken, 1);
    drv(ctl(4'd0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0), 32'hFFFFFFFF, 32'd1);
    tick();
    chk("blt_taken", o_br_taken, 1);
    drv(ctl(4'd0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 0), 32'd1, 32'hFFFFFFFF);
    tick();
    chk("blt_not", o_br_taken, 0);
    drv(ctl(4'd0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0), 32'd1, 32'd2);
    tick();
    chk("bal_taken", o_br_taken, 1);
    i_valid = 1'b0;
    tick();
    chk("br_pulse", o_br_taken, 0);

    // MUL -3*4: stall 16 cycles including the accept cycle
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 1, 0, 0), 32'hFFFFFFFD, 32'd4);
    #1 chk("mul_stall0", o_stall, 1);
    n = 1;
    tick(); i_valid = 1'b0;
    while (o_stall === 1'b1 && n < 40) begin n++; tick(); end
    chk("mul_stall_cycles", n, 16);
    chk("mul_valid", o_valid, 1);
    chk("mul_result", o_result, 32'hFFFFFFF4);
    chk("mul_memctrl", o_mem_ctrl, 3'b100);
    tick();
    chk("mul_valid_drop", o_valid, 0);

    // MAC chain: clr 2*3, then 4*5 issued in the DONE cycle
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 1), 32'd2, 32'd3);
    tick(); i_valid = 1'b0;
    wait_valid(n);
    chk("mac1_lat", n, 15);
    chk("mac1_result", o_result, 6);
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 0), 32'd4, 32'd5);
    #1 chk("mac2_accept", o_stall, 1);
    tick(); i_valid = 1'b0;
    wait_valid(n);
    chk("mac2_lat", n, 15);
    chk("mac2_result", o_result, 26);

    // flush a MAC mid-flight
    tick();
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 0), 32'd6, 32'd7);
    tick(); i_valid = 1'b0;
    tick(); tick(); tick(); tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    #1 chk("flush_valid", o_valid, 0);
    chk("flush_stall", o_stall, 0);
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0), 32'd1, 32'd1);
    tick();
    chk("post_flush_add", o_result, 2);
    chk("post_flush_valid", o_valid, 1);
    i_valid = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (o_valid === 1'b1) vcnt++; end
    chk("flush_no_late_valid", vcnt, 0);
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 0), 32'd0, 32'd0);
    tick(); i_valid = 1'b0;
    wait_valid(n);
    chk("acc_kept", o_result, 26);

    // MAC overflow behaviour
    tick();
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 1), 32'h7FFFFFF0, 32'd1);
    tick(); i_valid = 1'b0;
    wait_valid(n);
    chk("acc_load", o_result, 32'h7FFFFFF0);
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 0, 1, 0), 32'd1, 32'h20);
    tick(); i_valid = 1'b0;
    wait_valid(n);
`ifdef EXE_MAC_SAT_EN
    chk("mac_sat", o_result, 32'h7FFFFFFF);
`else
    chk("mac_wrap", o_result, 32'h80000010);
`endif

    // reset in the middle of a MUL
    tick();
    drv(ctl(4'd0, 0, 0, 0, 1, 0, 2'b00, 1, 0, 0), 32'd3, 32'd3);
    tick(); i_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("rstm_valid", o_valid, 0);
    chk("rstm_stall", o_stall, 0);
    chk("rstm_result", o_result, 0);
    chk("rstm_addr", o_addr, 0);
    chk("rstm_target", o_br_target, 0);
    chk("rstm_memctrl", o_mem_ctrl, 0);
    rst_n = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (o_valid === 1'b1) vcnt++; end
    chk("rstm_no_late_valid", vcnt, 0);
    drv(ctl(4'd0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0), 32'd0, 32'd0);
    tick(); i_valid = 1'b0;
    wait_valid(n);
    chk("rstm_acc_zero", o_result, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
